seq_detect_param: RTL

- Parametrised serial sequence detector for push-button/switch labs.
- On each qualified strobe `key_p`, samples serial bit `sw` and compares the recent history against a run-time programmable pattern of programmable length.
- Drives a match LED, a one-cycle match pulse, a saturating match counter and a progress indicator.
- Sits between the key debouncer/edge detector and the LED/segment display logic.
- Supports overlapping and non-overlapping detection modes.

---
 rtl/seq_detect_param.sv | 97 +++++++++
 1 files changed

// File: rtl/seq_detect_param.sv
// Serial pattern detector with run-time programmable pattern, length and overlap mode.
// One-cycle latency from the accepted key_p to match_p/led/match_count; no backpressure, it samples only on key_p.
module seq_detect_param #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_p,
    input  logic             sw,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    output logic             led,
    output logic             match_p,
    output logic [CNT_W-1:0] match_count,
    output logic [LEN_W-1:0] state_count
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);

    logic [PAT_W-1:0] hist;
    logic [PAT_W-1:0] hist_nxt;
    logic [PAT_W-1:0] pat_q;
    logic [PAT_W-1:0] mask;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_in;
    logic [LEN_W-1:0] depth;
    logic [LEN_W-1:0] depth_inc;
    logic             ov_q;
    logic             hit;

    // Out-of-range lengths (including 0) select the full register width.
    always_comb begin
        len_in = cfg_len;
        if (cfg_len == '0 || cfg_len > LEN_MAX) begin
            len_in = LEN_MAX;
        end
    end

    always_comb begin
        mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            mask[i] = (LEN_W'(i) < len_q);
        end
    end

    // depth is the pre-sample count, so widen by one bit to keep depth+1 exact.
    always_comb begin
        hist_nxt  = {hist[PAT_W-2:0], sw};
        depth_inc = (depth < len_q) ? depth + LEN_W'(1) : len_q;
        hit       = (({1'b0, depth} + {{LEN_W{1'b0}}, 1'b1}) >= {1'b0, len_q}) &&
                    ((hist_nxt & mask) == (pat_q & mask));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist        <= '0;
            depth       <= '0;
            pat_q       <= '0;
            len_q       <= LEN_W'(1);
            ov_q        <= 1'b1;
            led         <= 1'b0;
            match_p     <= 1'b0;
            match_count <= '0;
        end else begin
            match_p <= 1'b0;
            if (cfg_load) begin
                pat_q       <= cfg_pattern;
                len_q       <= len_in;
                ov_q        <= cfg_overlap;
                hist        <= '0;
                depth       <= '0;
                match_count <= '0;
                led         <= 1'b0;
            end else if (key_p) begin
                hist <= hist_nxt;
                if (hit) begin
                    match_p <= 1'b1;
                    led     <= 1'b1;
                    if (match_count != '1) begin
                        match_count <= match_count + CNT_W'(1);
                    end
                    depth <= ov_q ? depth_inc : '0;
                end else begin
                    led   <= 1'b0;
                    depth <= depth_inc;
                end
            end
        end
    end

    assign state_count = depth;

endmodule
